// File: rtl/dma_fifo_v2_if.sv
// dma_fifo_v2_if: clock and active-low reset bundle shared by the FIFO and whatever drives it.
interface AXI_clks;
    logic clk;
    logic rst;
    modport to_rtl (input clk, rst);
    modport master (output clk, rst);
endinterface

// File: rtl/dma_fifo_v2.sv
// dma_fifo_v2: single-clock DMA staging FIFO with FWFT/registered read, level flags,
// sticky error flags, synchronous flush and peak-occupancy monitor.
module dma_fifo_v2 #(
    parameter int DWIDTH        = 32,
    parameter int AWIDTH        = 5,
    parameter int AFULL_THRESH  = (1 << AWIDTH) - 2,
    parameter int AEMPTY_THRESH = 2,
    parameter bit FWFT          = 1'b1
) (
    AXI_clks.to_rtl           clks,
    input  logic              flush,
    input  logic              push,
    input  logic [DWIDTH-1:0] data_in,
    input  logic              pull,
    output logic [DWIDTH-1:0] data_out,
    output logic              rd_valid,
    output logic [AWIDTH:0]   depth_left,
    output logic [AWIDTH:0]   level,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow,
    output logic [AWIDTH:0]   max_level
);
    localparam int FIFO_DEPTH = 1 << AWIDTH;
    localparam logic [AWIDTH:0] DEPTH_V = (AWIDTH+1)'(FIFO_DEPTH);
    logic [DWIDTH-1:0] mem [FIFO_DEPTH];
    logic [AWIDTH-1:0] w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d;
    logic [AWIDTH:0] level_q, level_d, max_level_q, max_level_d;
    logic overflow_q, overflow_d, underflow_q, underflow_d, rd_valid_q, rd_valid_d;
    logic [DWIDTH-1:0] dout_q, dout_d;
    logic rd_en, wr_en;
    assign level        = level_q;
    assign depth_left   = DEPTH_V - level_q;
    assign full         = level_q == DEPTH_V;
    assign empty        = level_q == '0;
    assign almost_full  = int'(level_q) >= AFULL_THRESH;
    assign almost_empty = int'(level_q) <= AEMPTY_THRESH;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
    assign max_level    = max_level_q;
    assign rd_valid     = FWFT ? !empty : rd_valid_q;
    assign data_out     = FWFT ? (empty ? '0 : mem[r_ptr_q]) : dout_q;
    // A full FIFO still accepts a push when a pull frees the head slot in the same cycle.
    always_comb begin
        rd_en       = !flush && pull && !empty;
        wr_en       = !flush && push && (!full || pull);
        w_ptr_d     = flush ? '0 : w_ptr_q + AWIDTH'(wr_en);
        r_ptr_d     = flush ? '0 : r_ptr_q + AWIDTH'(rd_en);
        level_d     = flush ? '0 : level_q + (AWIDTH+1)'(wr_en) - (AWIDTH+1)'(rd_en);
        max_level_d = flush ? '0 : (level_d > max_level_q ? level_d : max_level_q);
        overflow_d  = !flush && (overflow_q || (push && full && !pull));
        underflow_d = !flush && (underflow_q || (pull && empty));
        rd_valid_d  = rd_en;
        dout_d      = flush ? '0 : (rd_en ? mem[r_ptr_q] : dout_q);
    end
    always_ff @(posedge clks.clk or negedge clks.rst) begin
        if (!clks.rst) begin
            w_ptr_q     <= '0;
            r_ptr_q     <= '0;
            level_q     <= '0;
            max_level_q <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            dout_q      <= '0;
        end else begin
            w_ptr_q     <= w_ptr_d;
            r_ptr_q     <= r_ptr_d;
            level_q     <= level_d;
            max_level_q <= max_level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            rd_valid_q  <= rd_valid_d;
            dout_q      <= dout_d;
        end
    end
    always_ff @(posedge clks.clk) begin
        if (wr_en) mem[w_ptr_q] <= data_in;
    end
    a_level_max: assert property (@(posedge clks.clk) disable iff (!clks.rst) level_q <= DEPTH_V);
    a_full_empty: assert property (@(posedge clks.clk) disable iff (!clks.rst) !(full && empty));
    a_depth_sum: assert property (@(posedge clks.clk) disable iff (!clks.rst) depth_left + level_q == DEPTH_V);
endmodule

// File: tb/tb_dma_fifo_v2.sv
// tb_dma_fifo_v2: table-driven check of an FWFT depth-4 FIFO with a data scoreboard,
// plus hand sequences for registered read (second instance) and mid-operation reset.
module tb_dma_fifo_v2;
    localparam int DEPTH = 4;
    AXI_clks clks_i ();
    logic flush, push, pull;
    logic [7:0] din, dout;
    logic rd_valid, full, empty, af, ae, ovf, udf;
    logic [2:0] level, depth_left, max_level;
    logic b_flush, b_push, b_pull;
    logic [7:0] b_din, b_dout;
    logic b_rd_valid, b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
    logic [2:0] b_level, b_depth_left, b_max_level;
    int errors = 0;
    int checks = 0;
    logic [7:0] sb [$];
    typedef struct {
        logic fl, ps, pl;
        logic [7:0] d;
        int lvl, ovf, udf, mx, dout;
    } vec_t;
    vec_t tbl [$];

    dma_fifo_v2 #(.DWIDTH(8), .AWIDTH(2), .FWFT(1'b1)) u_a (
        .clks(clks_i), .flush(flush), .push(push), .data_in(din), .pull(pull),
        .data_out(dout), .rd_valid(rd_valid), .depth_left(depth_left), .level(level),
        .full(full), .empty(empty), .almost_full(af), .almost_empty(ae),
        .overflow(ovf), .underflow(udf), .max_level(max_level));

    dma_fifo_v2 #(.DWIDTH(8), .AWIDTH(2), .FWFT(1'b0)) u_b (
        .clks(clks_i), .flush(b_flush), .push(b_push), .data_in(b_din), .pull(b_pull),
        .data_out(b_dout), .rd_valid(b_rd_valid), .depth_left(b_depth_left), .level(b_level),
        .full(b_full), .empty(b_empty), .almost_full(b_af), .almost_empty(b_ae),
        .overflow(b_ovf), .underflow(b_udf), .max_level(b_max_level));

    initial clks_i.clk = 1'b0;
    always #5 clks_i.clk = ~clks_i.clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic f, input logic p, input logic l, input logic [7:0] d);
        flush = f; push = p; pull = l; din = d;
        @(negedge clks_i.clk);
        if (!f && l && sb.size() > 0) begin
            chk("head_data", int'(dout), int'(sb[0]));
            chk("head_valid", int'(rd_valid), 1);
        end
        if (f) sb.delete();
        else begin
            automatic bit was_full = sb.size() == DEPTH;
            if (l && sb.size() > 0) void'(sb.pop_front());
            if (p && (!was_full || l)) sb.push_back(d);
        end
        @(posedge clks_i.clk);
        #1;
        flush = 1'b0; push = 1'b0; pull = 1'b0;
    endtask

    task automatic post(input int r, input vec_t v);
        chk($sformatf("r%0d_level", r), int'(level), v.lvl);
        chk($sformatf("r%0d_depth_left", r), int'(depth_left), DEPTH - v.lvl);
        chk($sformatf("r%0d_full", r), int'(full), int'(v.lvl == DEPTH));
        chk($sformatf("r%0d_empty", r), int'(empty), int'(v.lvl == 0));
        chk($sformatf("r%0d_almost_full", r), int'(af), int'(v.lvl >= 2));
        chk($sformatf("r%0d_almost_empty", r), int'(ae), int'(v.lvl <= 2));
        chk($sformatf("r%0d_overflow", r), int'(ovf), v.ovf);
        chk($sformatf("r%0d_underflow", r), int'(udf), v.udf);
        chk($sformatf("r%0d_max_level", r), int'(max_level), v.mx);
        chk($sformatf("r%0d_data_out", r), int'(dout), v.dout);
        chk($sformatf("r%0d_rd_valid", r), int'(rd_valid), int'(v.lvl != 0));
    endtask

    initial begin
        clks_i.rst = 1'b0;
        {flush, push, pull, din} = '0;
        {b_flush, b_push, b_pull, b_din} = '0;
        // fl ps pl data lvl ovf udf max dout
        tbl.push_back('{0, 1, 0, 8'h11, 1, 0, 0, 1, 'h11});
        tbl.push_back('{0, 1, 0, 8'h22, 2, 0, 0, 2, 'h11});
        tbl.push_back('{0, 1, 0, 8'h33, 3, 0, 0, 3, 'h11});
        tbl.push_back('{0, 1, 0, 8'h44, 4, 0, 0, 4, 'h11});
        tbl.push_back('{0, 0, 1, 8'h00, 3, 0, 0, 4, 'h22});
        tbl.push_back('{0, 0, 1, 8'h00, 2, 0, 0, 4, 'h33});
        tbl.push_back('{0, 0, 1, 8'h00, 1, 0, 0, 4, 'h44});
        tbl.push_back('{0, 0, 1, 8'h00, 0, 0, 0, 4, 'h00});
        tbl.push_back('{0, 1, 0, 8'h01, 1, 0, 0, 4, 'h01});
        tbl.push_back('{0, 1, 0, 8'h02, 2, 0, 0, 4, 'h01});
        tbl.push_back('{0, 1, 0, 8'h03, 3, 0, 0, 4, 'h01});
        tbl.push_back('{0, 1, 0, 8'h04, 4, 0, 0, 4, 'h01});
        tbl.push_back('{0, 1, 1, 8'h55, 4, 0, 0, 4, 'h02});
        tbl.push_back('{0, 1, 0, 8'h66, 4, 1, 0, 4, 'h02});
        tbl.push_back('{0, 0, 1, 8'h00, 3, 1, 0, 4, 'h03});
        tbl.push_back('{0, 0, 1, 8'h00, 2, 1, 0, 4, 'h04});
        tbl.push_back('{0, 0, 1, 8'h00, 1, 1, 0, 4, 'h55});
        tbl.push_back('{0, 0, 1, 8'h00, 0, 1, 0, 4, 'h00});
        tbl.push_back('{0, 1, 1, 8'hA5, 1, 1, 1, 4, 'hA5});
        tbl.push_back('{0, 0, 1, 8'h00, 0, 1, 1, 4, 'h00});
        tbl.push_back('{1, 0, 0, 8'h00, 0, 0, 0, 0, 'h00});
        tbl.push_back('{0, 1, 0, 8'h61, 1, 0, 0, 1, 'h61});
        tbl.push_back('{0, 1, 0, 8'h62, 2, 0, 0, 2, 'h61});
        tbl.push_back('{0, 1, 0, 8'h63, 3, 0, 0, 3, 'h61});
        tbl.push_back('{0, 1, 1, 8'h64, 3, 0, 0, 3, 'h62});
        tbl.push_back('{0, 1, 1, 8'h65, 3, 0, 0, 3, 'h63});
        tbl.push_back('{0, 1, 1, 8'h66, 3, 0, 0, 3, 'h64});
        tbl.push_back('{1, 1, 1, 8'h77, 0, 0, 0, 0, 'h00});
        tbl.push_back('{0, 1, 0, 8'h99, 1, 0, 0, 1, 'h99});
        tbl.push_back('{0, 0, 1, 8'h00, 0, 0, 0, 1, 'h00});
        #12;
        chk("rst_level", int'(level), 0);
        chk("rst_depth_left", int'(depth_left), DEPTH);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_almost_full", int'(af), 0);
        chk("rst_almost_empty", int'(ae), 1);
        chk("rst_flags", int'({ovf, udf}), 0);
        chk("rst_data_out", int'(dout), 0);
        chk("rst_rd_valid", int'(rd_valid), 0);
        chk("rst_b_data_out", int'(b_dout), 0);
        chk("rst_b_rd_valid", int'(b_rd_valid), 0);
        clks_i.rst = 1'b1;
        @(posedge clks_i.clk);
        #1;
        foreach (tbl[i]) begin
            step(tbl[i].fl, tbl[i].ps, tbl[i].pl, tbl[i].d);
            post(i, tbl[i]);
        end
        b_push = 1'b1; b_din = 8'h01;
        @(posedge clks_i.clk);
        #1;
        b_din = 8'h02;
        @(posedge clks_i.clk);
        #1;
        b_push = 1'b0;
        chk("b_level2", int'(b_level), 2);
        chk("b_idle_valid", int'(b_rd_valid), 0);
        b_pull = 1'b1;
        @(posedge clks_i.clk);
        #1;
        chk("b_rd1_valid", int'(b_rd_valid), 1);
        chk("b_rd1_data", int'(b_dout), 'h01);
        @(posedge clks_i.clk);
        #1;
        chk("b_rd2_valid", int'(b_rd_valid), 1);
        chk("b_rd2_data", int'(b_dout), 'h02);
        b_pull = 1'b0;
        @(posedge clks_i.clk);
        #1;
        chk("b_after_valid", int'(b_rd_valid), 0);
        chk("b_after_hold", int'(b_dout), 'h02);
        chk("b_after_empty", int'(b_empty), 1);
        chk("b_underflow", int'(b_udf), 0);
        step(0, 1, 0, 8'hC1);
        step(0, 1, 0, 8'hC2);
        step(0, 1, 0, 8'hC3);
        chk("pre_rst_level", int'(level), 3);
        #2;
        clks_i.rst = 1'b0;
        #1;
        chk("mid_rst_level", int'(level), 0);
        chk("mid_rst_empty", int'(empty), 1);
        chk("mid_rst_depth_left", int'(depth_left), DEPTH);
        chk("mid_rst_data_out", int'(dout), 0);
        chk("mid_rst_max_level", int'(max_level), 0);
        sb.delete();
        @(negedge clks_i.clk);
        clks_i.rst = 1'b1;
        @(posedge clks_i.clk);
        #1;
        step(0, 1, 0, 8'h7E);
        chk("post_rst_data", int'(dout), 'h7E);
        step(0, 0, 1, 8'h00);
        chk("post_rst_empty", int'(empty), 1);
        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
